// File: rtl/instr_sequencer_if.sv
// Instruction handshake between the program sequencer (master) and the cpu (slave).
interface instr_sequencer_if;
   logic        load;
   logic        start;
   logic [15:0] instr;
   logic        waiting;
   logic [15:0] cpu_out;
   logic        cpu_n;
   logic        cpu_v;
   logic        cpu_z;

   modport master (output load, start, instr, input waiting, cpu_out, cpu_n, cpu_v, cpu_z);
   modport slave  (input load, start, instr, output waiting, cpu_out, cpu_n, cpu_v, cpu_z);
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: stores a short program and feeds it to the cpu one instruction
// at a time, capturing each result and flagging a cpu that stops completing.
module instr_sequencer #(
   parameter int  DEPTH   = 16,
   parameter int  TIMEOUT = 64,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   instr_sequencer_if.master cpu,
   input  logic              prog_we,
   input  logic [AW-1:0]     prog_addr,
   input  logic [15:0]       prog_data,
   input  logic [AW:0]       prog_len,
   input  logic              run,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [AW-1:0]     pc,
   output logic [15:0]       result,
   output logic [2:0]        flags,
   output logic              result_valid
);
   localparam int              AW1     = AW + 1;
   localparam int              WW      = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [AW:0]     DEPTH_L = AW1'(DEPTH);
   localparam logic [AW:0]     PC_INC  = AW1'(1);
   localparam logic [WW-1:0]   WD_INC  = WW'(1);
   localparam logic [WW-1:0]   WD_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, EXEC_LO, EXEC_HI, DONE, ERR} state_t;

   state_t        state;
   logic [15:0]   mem [DEPTH];
   logic [AW:0]   len;
   logic [WW-1:0] wdog;
   logic [15:0]   instr_q;
   logic [AW:0]   pc_next;
   logic          last_s;
   logic          timeout_s;

   assign pc_next   = {1'b0, pc} + PC_INC;
   assign last_s    = (pc_next == len);
   assign timeout_s = (wdog == WD_LAST);

   // The cpu samples load/start on the same edge that it leaves Waiting, so these
   // must follow waiting within the ISSUE cycle.
   assign cpu.load  = (state == ISSUE) && cpu.waiting;
   assign cpu.start = (state == ISSUE) && cpu.waiting;
   assign cpu.instr = instr_q;

   // Program storage; survives reset and is only writable while idle.
   always_ff @(posedge clk) begin
      if (prog_we && (state == IDLE)) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // Sequencer FSM, watchdog and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         len          <= '0;
         wdog         <= '0;
         instr_q      <= 16'h0000;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         pc           <= '0;
         result       <= 16'h0000;
         flags        <= 3'b000;
         result_valid <= 1'b0;
      end else begin
         done         <= 1'b0;
         result_valid <= 1'b0;
         if ((state != IDLE) && abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            instr_q <= 16'h0000;
         end else begin
            case (state)
               IDLE: begin
                  if (run) begin
                     len  <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                     pc   <= '0;
                     err  <= 1'b0;
                     wdog <= '0;
                     busy <= 1'b1;
                     if (prog_len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state   <= ISSUE;
                        instr_q <= mem[0];
                     end
                  end
               end
               ISSUE: begin
                  wdog <= wdog + WD_INC;
                  if (timeout_s) begin
                     state   <= ERR;
                     err     <= 1'b1;
                     instr_q <= 16'h0000;
                  end else if (cpu.waiting) begin
                     state   <= EXEC_LO;
                     instr_q <= 16'h0000;
                  end else begin
                     state <= ISSUE;
                  end
               end
               EXEC_LO: begin
                  wdog <= wdog + WD_INC;
                  if (timeout_s) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else if (!cpu.waiting) begin
                     state <= EXEC_HI;
                  end else begin
                     state <= EXEC_LO;
                  end
               end
               EXEC_HI: begin
                  wdog <= wdog + WD_INC;
                  // Completion in the final allowed cycle still counts as on time.
                  if (cpu.waiting) begin
                     result       <= cpu.cpu_out;
                     flags        <= {cpu.cpu_n, cpu.cpu_v, cpu.cpu_z};
                     result_valid <= 1'b1;
                     if (last_s) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state   <= ISSUE;
                        pc      <= pc_next[AW-1:0];
                        instr_q <= mem[pc_next[AW-1:0]];
                        wdog    <= '0;
                     end
                  end else if (timeout_s) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else begin
                     state <= EXEC_HI;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               ERR: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  instr_q <= 16'h0000;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a small cpu stub answers each issued
// instruction, a vector table covers whole programs, hand sequences cover corners.
module tb_instr_sequencer;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [15:0]   prog_data;
   logic [AW:0]   prog_len;
   logic          run;
   logic          abort;
   logic          busy, done, err, result_valid;
   logic [AW-1:0] pc;
   logic [15:0]   result;
   logic [2:0]    flags;

   int checks = 0;
   int errors = 0;

   instr_sequencer_if bus ();

   instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .cpu(bus),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_len(prog_len), .run(run), .abort(abort),
      .busy(busy), .done(done), .err(err), .pc(pc),
      .result(result), .flags(flags), .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   // cpu stub: MOV (Dxxx) is busy 2 cycles, anything else 5; stall freezes it.
   logic        cw;
   logic        stall;
   int          cnt;
   logic [15:0] ir;
   logic [15:0] regs [8];
   logic [15:0] c_out;
   logic [2:0]  c_flags;
   logic [15:0] alu_s;

   assign bus.waiting = cw;
   assign bus.cpu_out = c_out;
   assign {bus.cpu_n, bus.cpu_v, bus.cpu_z} = c_flags;
   assign alu_s = (ir == 16'hA041) ? regs[0] + regs[1] :
                  (ir == 16'hA800) ? regs[0] - regs[0] : ir;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cw      <= 1'b1;
         cnt     <= 0;
         ir      <= 16'h0000;
         c_out   <= 16'h0000;
         c_flags <= 3'b000;
      end else if (cw) begin
         if (bus.load && bus.start) begin
            ir  <= bus.instr;
            cnt <= (bus.instr[15:12] == 4'hD) ? 1 : 4;
            cw  <= 1'b0;
         end
      end else if (!stall) begin
         if (cnt == 0) begin
            cw <= 1'b1;
            if (ir[15:12] == 4'hD) begin
               c_out            <= {8'h00, ir[7:0]};
               regs[ir[10:8]]   <= {8'h00, ir[7:0]};
               c_flags          <= {2'b00, ir[7:0] == 8'h00};
            end else begin
               c_out   <= alu_s;
               c_flags <= {alu_s[15], 1'b0, alu_s == 16'h0000};
               if (ir == 16'hA041) regs[2] <= alu_s;
            end
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   typedef struct {
      logic [15:0]   w0, w1, w2;
      int            nw;
      logic [AW:0]   len;
      int            ncyc;
      logic [15:0]   res;
      logic [2:0]    fl;
      logic [AW-1:0] epc;
      int            edone;
      int            nrv;
      int            rv0, rv1, rv2;
   } vec_t;
   vec_t vecs [5];

   int          rv_q[$];
   int          done_q[$];
   int          load_cnt;
   int          err_cyc;
   int          idle_cyc;
   logic [15:0] first_instr;
   logic        busy1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic write_mem(input logic [AW-1:0] a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Called at a negedge (cycle 0): raises run and logs events for cycles 1..ncyc.
   task automatic watch(input int ncyc, input int abort_cyc, input int we_cyc, input logic [15:0] we_data);
      rv_q.delete(); done_q.delete();
      load_cnt = 0; err_cyc = -1; idle_cyc = -1; first_instr = 16'h0000; busy1 = 1'b0;
      run = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         run       = 1'b0;
         abort     = (k == abort_cyc);
         prog_we   = (k == we_cyc);
         prog_addr = '0;
         prog_data = we_data;
         if (k == 1) busy1 = busy;
         if (result_valid) rv_q.push_back(k);
         if (done) done_q.push_back(k);
         if (bus.load || bus.start) begin
            if (load_cnt == 0) first_instr = bus.instr;
            load_cnt++;
         end
         if (err && err_cyc < 0) err_cyc = k;
         if (!busy && idle_cyc < 0) idle_cyc = k;
      end
      abort = 1'b0; prog_we = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},   busy,         1'b0);
      check({tag, "_done"},   done,         1'b0);
      check({tag, "_err"},    err,          1'b0);
      check({tag, "_rv"},     result_valid, 1'b0);
      check({tag, "_pc"},     pc,           4'd0);
      check({tag, "_result"}, result,       16'h0000);
      check({tag, "_flags"},  flags,        3'b000);
      check({tag, "_load"},   bus.load,     1'b0);
      check({tag, "_start"},  bus.start,    1'b0);
      check({tag, "_instr"},  bus.instr,    16'h0000);
   endtask

   initial begin
      vecs[0] = '{16'hD005, 16'hD103, 16'hA041, 3, 5'd3,  20, 16'h0008, 3'b000, 4'd2,  16, 3,  5,  9, 16};
      vecs[1] = '{16'hD007, 16'hA800, 16'h0000, 2, 5'd2,  16, 16'h0000, 3'b001, 4'd1,  12, 2,  5, 12, -1};
      vecs[2] = '{16'hD0FF, 16'h0000, 16'h0000, 1, 5'd1,   8, 16'h00FF, 3'b000, 4'd0,   5, 1,  5, -1, -1};
      vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 0, 5'd0,   5, 16'h00FF, 3'b000, 4'd0,   1, 0, -1, -1, -1};
      vecs[4] = '{16'hD000, 16'hD001, 16'hD002, 3, 5'd17, 70, 16'h000F, 3'b000, 4'd15, 65, 16, 5,  9, 13};

      prog_we = 1'b0; prog_addr = '0; prog_data = 16'h0000; prog_len = '0;
      run = 1'b0; abort = 1'b0; stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < DEPTH; i++) write_mem(AW'(i), 16'hD000 | 16'(i));

      for (int i = 0; i < 5; i++) begin
         if (vecs[i].nw > 0) write_mem(4'd0, vecs[i].w0);
         if (vecs[i].nw > 1) write_mem(4'd1, vecs[i].w1);
         if (vecs[i].nw > 2) write_mem(4'd2, vecs[i].w2);
         prog_len = vecs[i].len;
         watch(vecs[i].ncyc, 0, 0, 16'h0000);
         check($sformatf("v%0d_done_cyc", i), done_q.size() > 0 ? done_q[0] : -1, vecs[i].edone);
         check($sformatf("v%0d_done_cnt", i), done_q.size(), 1);
         check($sformatf("v%0d_rv_cnt", i), rv_q.size(), vecs[i].nrv);
         if (vecs[i].rv0 >= 0) check($sformatf("v%0d_rv0", i), rv_q.size() > 0 ? rv_q[0] : -1, vecs[i].rv0);
         if (vecs[i].rv1 >= 0) check($sformatf("v%0d_rv1", i), rv_q.size() > 1 ? rv_q[1] : -1, vecs[i].rv1);
         if (vecs[i].rv2 >= 0) check($sformatf("v%0d_rv2", i), rv_q.size() > 2 ? rv_q[2] : -1, vecs[i].rv2);
         if (vecs[i].nrv > 0) check($sformatf("v%0d_rv_last", i), rv_q[rv_q.size() - 1], vecs[i].edone);
         check($sformatf("v%0d_loads", i), load_cnt, vecs[i].nrv);
         if (vecs[i].nw > 0 && vecs[i].len > 0) check($sformatf("v%0d_instr0", i), first_instr, vecs[i].w0);
         check($sformatf("v%0d_busy1", i), busy1, 1'b1);
         check($sformatf("v%0d_idle", i), idle_cyc, vecs[i].edone + 1);
         check($sformatf("v%0d_result", i), result, vecs[i].res);
         check($sformatf("v%0d_flags", i), flags, vecs[i].fl);
         check($sformatf("v%0d_pc", i), pc, vecs[i].epc);
         check($sformatf("v%0d_err", i), err, 1'b0);
         repeat (2) @(negedge clk);
      end

      // Watchdog: cpu never returns to waiting after the issue.
      stall = 1'b1;
      write_mem(4'd0, 16'hD001);
      prog_len = 5'd1;
      watch(70, 0, 0, 16'h0000);
      check("to_err_cyc", err_cyc, 65);
      check("to_idle_cyc", idle_cyc, 66);
      check("to_no_done", done_q.size(), 0);
      check("to_no_rv", rv_q.size(), 0);
      check("to_err_sticky", err, 1'b1);
      stall = 1'b0;
      repeat (4) @(negedge clk);
      prog_len = 5'd0;
      watch(3, 0, 0, 16'h0000);
      check("to_err_cleared", err, 1'b0);
      check("to_rerun_done", done_q.size() > 0 ? done_q[0] : -1, 1);

      // Abort in the detect cycle of instruction 2 of 3.
      write_mem(4'd0, 16'hD011);
      write_mem(4'd1, 16'hD022);
      write_mem(4'd2, 16'hD033);
      prog_len = 5'd3;
      watch(14, 8, 0, 16'h0000);
      check("ab_idle_cyc", idle_cyc, 9);
      check("ab_no_done", done_q.size(), 0);
      check("ab_rv_cnt", rv_q.size(), 1);
      check("ab_result", result, 16'h0011);
      check("ab_pc", pc, 4'd1);
      repeat (2) @(negedge clk);

      // run with a same-cycle write, then a write while busy that must be dropped.
      write_mem(4'd0, 16'hD044);
      prog_len = 5'd1;
      prog_we = 1'b1; prog_addr = '0; prog_data = 16'hD055;
      watch(8, 0, 2, 16'hD0EE);
      check("we_first_result", result, 16'h0044);
      check("we_first_done", done_q.size() > 0 ? done_q[0] : -1, 5);
      watch(8, 0, 0, 16'h0000);
      check("we_rerun_instr", first_instr, 16'hD055);
      check("we_rerun_result", result, 16'h0055);

      // Asynchronous reset in the middle of a program; memory must survive.
      write_mem(4'd0, 16'hD066);
      write_mem(4'd1, 16'hD077);
      prog_len = 5'd2;
      watch(6, 0, 0, 16'h0000);
      check("rst_busy_before", busy, 1'b1);
      #2 rst = 1'b1;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      prog_len = 5'd1;
      watch(8, 0, 0, 16'h0000);
      check("rst_mem_kept", result, 16'h0066);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
